// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the requester, ALU and response signals of the shared-ALU arbiter.
//   slave  : the arbiter side (takes requests, drives the ALU, returns results)
//   master : the environment side (requesters, the ALU itself, response sink)
//   Requester i uses bit i of the per-requester vectors, [WIDTH*i +: WIDTH]
//   of the operand buses and [4*i +: 4] of req_ctrl.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ*WIDTH-1:0] req_in2;
    logic [NUM_REQ*4-1:0]     req_ctrl;
    logic [WIDTH-1:0]         alu_in1;
    logic [WIDTH-1:0]         alu_in2;
    logic [3:0]               alu_control;
    logic [WIDTH-1:0]         alu_result;
    logic                     zero_flag;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_zero;
    logic                     rsp_err;
    logic                     busy;

    modport slave (
        input  req_valid, req_in1, req_in2, req_ctrl, alu_result, zero_flag, rsp_ready,
        output req_ready, alu_in1, alu_in2, alu_control, rsp_valid, rsp_result,
               rsp_zero, rsp_err, busy
    );

    modport master (
        output req_valid, req_in1, req_in2, req_ctrl, alu_result, zero_flag, rsp_ready,
        input  req_ready, alu_in1, alu_in2, alu_control, rsp_valid, rsp_result,
               rsp_zero, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin share of one combinational 32-bit ALU among NUM_REQ requesters.
//   One operation at a time: IDLE (grant) -> EXEC (ALU driven) -> RESP (hold
//   result until the granted requester accepts it).
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_arbiter_if.slave -- request handshake, ALU drive/return,
//           response handshake and busy
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                           state;
    logic [IDX_W-1:0]                 ptr;      // last served requester
    logic [IDX_W-1:0]                 gnt;      // requester being served
    logic                             illegal;  // latched op carried a bad code
    logic [WIDTH-1:0]                 alu_in1_q, alu_in2_q;
    logic [3:0]                       alu_ctrl_q;
    logic [NUM_REQ-1:0]               rsp_valid_q;
    logic [WIDTH-1:0]                 rsp_result_q;
    logic                             rsp_zero_q, rsp_err_q;

    logic [NUM_REQ-1:0][WIDTH-1:0]    in1_v, in2_v;
    logic [NUM_REQ-1:0][3:0]          ctrl_v;
    logic                             grant_vld;
    logic [IDX_W-1:0]                 grant_idx;
    logic [IDX_W-1:0]                 scan;

    assign in1_v  = bus.req_in1;
    assign in2_v  = bus.req_in2;
    assign ctrl_v = bus.req_ctrl;

    function automatic logic is_legal(input logic [3:0] c);
        return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) ||
               (c == 4'b0100) || (c == 4'b1000);
    endfunction

    // Search starts one past the last served requester and wraps, so the
    // previous winner has lowest priority on the next grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (scan == IDX_W'(NUM_REQ - 1)) ? '0 : scan + IDX_W'(1);
            if (!grant_vld && bus.req_valid[scan]) begin
                grant_vld = 1'b1;
                grant_idx = scan;
            end
        end
    end

    assign bus.req_ready = (state == IDLE && grant_vld) ? (NUM_REQ'(1) << grant_idx) : '0;

    // ALU drive registers are loaded at grant and cleared leaving EXEC, so
    // the ALU sees operands only during EXEC and only for legal codes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= IDX_W'(NUM_REQ - 1);
            gnt          <= '0;
            illegal      <= 1'b0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_ctrl_q   <= 4'b0000;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        gnt     <= grant_idx;
                        illegal <= !is_legal(ctrl_v[grant_idx]);
                        if (is_legal(ctrl_v[grant_idx])) begin
                            alu_in1_q  <= in1_v[grant_idx];
                            alu_in2_q  <= in2_v[grant_idx];
                            alu_ctrl_q <= ctrl_v[grant_idx];
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (illegal) begin
                        rsp_result_q <= '0;
                        rsp_zero_q   <= 1'b1;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        rsp_result_q <= bus.alu_result;
                        rsp_zero_q   <= bus.zero_flag;
                        rsp_err_q    <= 1'b0;
                    end
                    alu_in1_q   <= '0;
                    alu_in2_q   <= '0;
                    alu_ctrl_q  <= 4'b0000;
                    rsp_valid_q <= NUM_REQ'(1) << gnt;
                    state       <= RESP;
                end
                RESP: begin
                    // Only the granted line's accept completes the response.
                    if (bus.rsp_ready[gnt]) begin
                        ptr         <= gnt;
                        rsp_valid_q <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_in1     = alu_in1_q;
    assign bus.alu_in2     = alu_in2_q;
    assign bus.alu_control = alu_ctrl_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed plus randomized bench for alu_arbiter with two requesters.
//   Provides a behavioural ALU on the ALU side, predicts the round-robin
//   winner and the response of every operation, and checks the handshake
//   timing, response hold and reset behaviour.
module tb_alu_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(N), .WIDTH(32)) bus();
    alu_arbiter    #(.NUM_REQ(N), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    // The shared ALU as seen from outside the arbiter.
    logic [31:0] alu_r;
    always_comb begin
        case (bus.alu_control)
            4'b0000: alu_r = bus.alu_in1 & bus.alu_in2;
            4'b0001: alu_r = bus.alu_in1 | bus.alu_in2;
            4'b0010: alu_r = bus.alu_in1 + bus.alu_in2;
            4'b0100: alu_r = bus.alu_in1 - bus.alu_in2;
            4'b1000: alu_r = {31'd0, bus.alu_in1 < bus.alu_in2};
            default: alu_r = 32'd0;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.zero_flag  = (alu_r == 32'd0);

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int last_w;
    int ctrl_bad;
    logic watch = 1'b0;

    always @(negedge clk) if (watch && bus.alu_control != 4'b0000) ctrl_bad++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what a requester should get back for one operation.
    task automatic ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic e);
        e = 1'b0;
        case (c)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd4:    r = a - b;
            4'd8:    r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        z = (r == 32'd0);
    endtask

    // Reference: first valid requester after the last one served.
    function automatic int rr_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (((v >> idx) & 1) != 0) return idx;
        end
        return 0;
    endfunction

    task automatic set_req(input int r, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[r]        = v;
        bus.req_ctrl[4*r +: 4]  = c;
        bus.req_in1[32*r +: 32] = a;
        bus.req_in2[32*r +: 32] = b;
    endtask

    // Called just after a rising edge with the DUT in IDLE and requests set.
    // Walks one full operation, holding the response 'hold' extra cycles
    // while the non-granted rsp_ready lines are high.
    task automatic serve(input int hold, output int w_obs);
        int w;
        logic [3:0]   c;
        logic [31:0]  a, b, r;
        logic         z, e;
        logic [N-1:0] one;
        #1;
        w   = rr_winner(bus.req_valid, last_w);
        one = '0;
        one[w] = 1'b1;
        chk("req_ready_grant", 32'(bus.req_ready), 32'(one));
        w_obs = -1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) w_obs = i;
        c = bus.req_ctrl[4*w +: 4];
        a = bus.req_in1[32*w +: 32];
        b = bus.req_in2[32*w +: 32];
        ref_op(c, a, b, r, z, e);
        @(posedge clk); #1;
        chk("busy_exec",      32'(bus.busy), 32'd1);
        chk("req_ready_exec", 32'(bus.req_ready), 32'd0);
        chk("rsp_valid_exec", 32'(bus.rsp_valid), 32'd0);
        chk("alu_control",    32'(bus.alu_control), e ? 32'd0 : 32'(c));
        chk("alu_in1",        bus.alu_in1, e ? 32'd0 : a);
        chk("alu_in2",        bus.alu_in2, e ? 32'd0 : b);
        @(posedge clk); #1;
        chk("rsp_valid",      32'(bus.rsp_valid), 32'(one));
        chk("rsp_result",     bus.rsp_result, r);
        chk("rsp_zero",       32'(bus.rsp_zero), 32'(z));
        chk("rsp_err",        32'(bus.rsp_err), 32'(e));
        chk("alu_idle_resp",  32'(bus.alu_control), 32'd0);
        repeat (hold) begin
            bus.rsp_ready = ~one;
            @(posedge clk); #1;
            chk("hold_rsp_valid",  32'(bus.rsp_valid), 32'(one));
            chk("hold_rsp_result", bus.rsp_result, r);
            chk("hold_rsp_zero",   32'(bus.rsp_zero), 32'(z));
            chk("hold_req_ready",  32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = one;
        @(posedge clk); #1;
        bus.rsp_ready = '0;
        chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
        chk("busy_done",      32'(bus.busy), 32'd0);
        last_w = w;
    endtask

    initial begin
        int w, prev;
        logic [3:0] codes [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd15};
        logic [N-1:0] mask;

        bus.req_valid = '0;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_w = N - 1;

        // Reset state
        chk("rst_busy",       32'(bus.busy), 32'd0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_zero",   32'(bus.rsp_zero), 32'd0);
        chk("rst_rsp_err",    32'(bus.rsp_err), 32'd0);
        chk("rst_alu_ctrl",   32'(bus.alu_control), 32'd0);
        chk("rst_alu_in1",    bus.alu_in1, 32'd0);
        chk("rst_req_ready",  32'(bus.req_ready), 32'd0);

        // 5 + 7 from requester 0
        set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
        serve(0, w);
        chk("first_winner", 32'(w), 32'd0);
        set_req(0, 1'b0, 4'b0010, 32'd5, 32'd7);
        @(posedge clk); #1;
        chk("idle_no_req_ready", 32'(bus.req_ready), 32'd0);

        // Both requesting ADD continuously: grants must alternate
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 4'b0010, $urandom, $urandom);
            set_req(1, 1'b1, 4'b0010, $urandom, $urandom);
            serve(0, w);
            chk("alternate", 32'(w != prev), 32'd1);
            prev = w;
        end
        set_req(0, 1'b0, 4'b0010, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'b0010, 32'd0, 32'd0);

        // SUB to zero with response held off for 4 cycles
        set_req(1, 1'b1, 4'b0100, 32'd9, 32'd9);
        serve(4, w);
        set_req(1, 1'b0, 4'b0100, 32'd9, 32'd9);

        // Illegal code: error response, ALU never driven
        ctrl_bad = 0;
        watch = 1'b1;
        set_req(0, 1'b1, 4'b0011, 32'd1, 32'd2);
        serve(1, w);
        watch = 1'b0;
        chk("illegal_alu_ctrl_idle", 32'(ctrl_bad), 32'd0);
        set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);

        // SLT both directions, then wrap-around ADD and underflowing SUB
        set_req(0, 1'b1, 4'b1000, 32'd3, 32'd8);
        serve(0, w);
        set_req(0, 1'b1, 4'b1000, 32'd8, 32'd3);
        serve(0, w);
        set_req(0, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        serve(0, w);
        set_req(0, 1'b1, 4'b0100, 32'd0, 32'd1);
        serve(0, w);
        set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);

        // Random mixes of requesters, codes (some illegal) and hold times
        for (int i = 0; i < 12; i++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++)
                set_req(r, mask[r], codes[$urandom_range(0, 6)], $urandom, $urandom);
            serve($urandom_range(0, 2), w);
        end
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 4'b0000, 32'd0, 32'd0);
        @(posedge clk); #1;

        // Reset during EXEC drops the operation and restores requester 0 priority
        set_req(1, 1'b1, 4'b0010, 32'd100, 32'd23);
        @(posedge clk); #1;
        chk("exec_before_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        set_req(0, 1'b1, 4'b0001, 32'hF0, 32'h0F);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy",       32'(bus.busy), 32'd0);
        chk("mid_rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rsp_result", bus.rsp_result, 32'd0);
        chk("mid_rst_alu_ctrl",   32'(bus.alu_control), 32'd0);
        last_w = N - 1;
        serve(0, w);
        chk("post_rst_winner", 32'(w), 32'd0);
        set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
        serve(0, w);
        chk("post_rst_second", 32'(w), 32'd1);
        set_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
